simon_sequencer: RTL and testbench



---
 rtl/simon_seq_if.sv | 42 ++++
 rtl/simon_sequencer.sv | 276 +++++++++++++++++++++++++++
 tb/tb_simon_sequencer.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/simon_seq_if.sv
// -----------------------------------------------------------------------------
// simon_seq_if
//   Groups the signals between the Simon game-control FSM (master) and the
//   sequence engine (slave). Clock and reset are not included; they stay as
//   plain ports on each module.
//
//   master -> slave : new_game, start_round, btn
//   slave -> master : random_seq, seq_active, end_of_sequence, input_valid,
//                     correct_input, round_complete, seq_length, max_reached
// -----------------------------------------------------------------------------
interface simon_seq_if #(
  parameter int MAX_LEN = 16
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  // Control side
  logic             new_game;        // pulse: clear sequence, go idle
  logic             start_round;     // pulse: append a colour, start playback
  logic [3:0]       btn;             // player buttons, one-hot colour, level

  // Sequence engine side
  logic [1:0]       random_seq;      // colour currently being played
  logic             seq_active;      // high during each colour's on window
  logic             end_of_sequence; // 1-cycle pulse: playback finished
  logic             input_valid;     // 1-cycle pulse: a press was judged
  logic             correct_input;   // result of the last judged press, held
  logic             round_complete;  // 1-cycle pulse: whole sequence entered
  logic [LEN_W-1:0] seq_length;      // current stored length
  logic             max_reached;     // stored length == MAX_LEN

  modport master (
    output new_game, start_round, btn,
    input  random_seq, seq_active, end_of_sequence, input_valid,
           correct_input, round_complete, seq_length, max_reached
  );

  modport slave (
    input  new_game, start_round, btn,
    output random_seq, seq_active, end_of_sequence, input_valid,
           correct_input, round_complete, seq_length, max_reached
  );
endinterface

// File: rtl/simon_sequencer.sv
// -----------------------------------------------------------------------------
// simon_sequencer
//   Sequence engine for the Simon game. Stores the growing colour sequence,
//   appends one pseudo-random colour per round, plays the sequence back with
//   fixed on/off timing and then judges each player press against the stored
//   colour.
//
// Ports
//   clk  : system clock
//   rst  : synchronous, active-high reset
//   bus  : simon_seq_if.slave
//            in  new_game, start_round, btn[3:0]
//            out random_seq[1:0], seq_active, end_of_sequence, input_valid,
//                correct_input, round_complete, seq_length[LEN_W-1:0],
//                max_reached
//
// Parameters
//   MAX_LEN          maximum sequence length (2-bit colours)
//   STEP_ON_CYCLES   cycles each colour is shown (>= 1)
//   STEP_OFF_CYCLES  gap cycles after each colour (>= 1)
//   LFSR_SEED        LFSR reset value; zero is replaced by 8'h01
// -----------------------------------------------------------------------------
module simon_sequencer #(
  parameter int         MAX_LEN         = 16,
  parameter int         STEP_ON_CYCLES  = 4,
  parameter int         STEP_OFF_CYCLES = 2,
  parameter logic [7:0] LFSR_SEED       = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  simon_seq_if.slave bus
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int STEP_MAX = (STEP_ON_CYCLES > STEP_OFF_CYCLES) ? STEP_ON_CYCLES
                                                               : STEP_OFF_CYCLES;
  localparam int CNT_W = (STEP_MAX > 1) ? $clog2(STEP_MAX) : 1;

  // An all-zero seed would lock the LFSR up, so it is replaced.
  localparam logic [7:0]       SEED      = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(STEP_ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_LAST  = CNT_W'(STEP_OFF_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PLAY_ON,
    ST_PLAY_OFF,
    ST_INPUT,
    ST_FAIL
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t           r_state;
  logic [7:0]       r_lfsr;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_play_idx;
  logic [LEN_W-1:0] r_input_idx;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_btn_prev;
  logic [1:0]       r_random_seq;
  logic             r_eos;
  logic             r_valid;
  logic             r_correct;
  logic             r_round_done;
  logic             r_max;
  logic [1:0]       r_mem [MAX_LEN];

  // ---------------------------------------------------------------------------
  // Next-state values
  // ---------------------------------------------------------------------------
  state_t           w_state_nxt;
  logic [LEN_W-1:0] w_len_nxt;
  logic [LEN_W-1:0] w_play_idx_nxt;
  logic [LEN_W-1:0] w_input_idx_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [1:0]       w_random_seq_nxt;
  logic             w_eos_nxt;
  logic             w_valid_nxt;
  logic             w_correct_nxt;
  logic             w_round_done_nxt;

  logic             w_wr_en;
  logic [IDX_W-1:0] w_wr_addr;

  logic             w_lfsr_fb;
  logic [LEN_W-1:0] w_base_len;
  logic             w_start_ok;
  logic             w_append;
  logic             w_press;
  logic             w_onehot;
  logic [1:0]       w_btn_col;
  logic             w_hit;
  logic [LEN_W-1:0] w_play_next;
  logic [LEN_W-1:0] w_input_next;

  // Fibonacci LFSR, x^8 + x^6 + x^5 + x^4 + 1.
  assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

  // new_game clears the length in the same cycle, so a simultaneous
  // start_round appends at index 0.
  assign w_base_len = bus.new_game ? '0 : r_len;

  // start_round is ignored during playback unless new_game aborts it first.
  assign w_start_ok = bus.start_round &&
                      (bus.new_game || (r_state == ST_IDLE) ||
                       (r_state == ST_INPUT) || (r_state == ST_FAIL));

  // A retry from FAIL replays the stored sequence without growing it.
  assign w_append  = w_start_ok && (w_base_len < MAX_LEN_V) &&
                     (bus.new_game || (r_state != ST_FAIL));
  assign w_wr_addr = w_base_len[IDX_W-1:0];

  // A press is a rising edge out of the all-released state; holding a button
  // or adding a second one does not re-trigger.
  assign w_press = (bus.btn != 4'b0000) && (r_btn_prev == 4'b0000);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned and no latch is inferred.
    w_onehot  = 1'b1;
    w_btn_col = 2'd0;
    case (bus.btn)
      4'b0001: w_btn_col = 2'd0;
      4'b0010: w_btn_col = 2'd1;
      4'b0100: w_btn_col = 2'd2;
      4'b1000: w_btn_col = 2'd3;
      default: w_onehot  = 1'b0;
    endcase
  end

  assign w_hit        = w_onehot && (w_btn_col == r_mem[r_input_idx[IDX_W-1:0]]);
  assign w_play_next  = r_play_idx + LEN_W'(1);
  assign w_input_next = r_input_idx + LEN_W'(1);

  // ---------------------------------------------------------------------------
  // Next-state / output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt      = r_state;
    w_len_nxt        = r_len;
    w_play_idx_nxt   = r_play_idx;
    w_input_idx_nxt  = r_input_idx;
    w_cnt_nxt        = r_cnt;
    w_random_seq_nxt = r_random_seq;
    w_eos_nxt        = 1'b0;
    w_valid_nxt      = 1'b0;
    w_correct_nxt    = r_correct;
    w_round_done_nxt = 1'b0;
    w_wr_en          = 1'b0;

    if (bus.new_game) begin
      w_state_nxt   = ST_IDLE;
      w_len_nxt     = '0;
      w_correct_nxt = 1'b0;
    end

    if (w_start_ok) begin
      if (w_append) begin
        w_wr_en   = 1'b1;
        w_len_nxt = w_base_len + LEN_W'(1);
      end
      w_play_idx_nxt  = '0;
      w_input_idx_nxt = '0;
      w_cnt_nxt       = '0;
      w_correct_nxt   = 1'b0;
      w_state_nxt     = ST_PLAY_ON;
      // Entry 0 is being written this same cycle when the sequence was empty,
      // so take the colour straight from the LFSR in that case.
      w_random_seq_nxt = (w_base_len == '0) ? r_lfsr[1:0] : r_mem[0];
    end else if (!bus.new_game) begin
      case (r_state)
        ST_PLAY_ON: begin
          if (r_cnt == ON_LAST) begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_PLAY_OFF;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end

        ST_PLAY_OFF: begin
          if (r_cnt == OFF_LAST) begin
            w_cnt_nxt = '0;
            if (w_play_next < r_len) begin
              w_play_idx_nxt   = w_play_next;
              w_random_seq_nxt = r_mem[w_play_next[IDX_W-1:0]];
              w_state_nxt      = ST_PLAY_ON;
            end else begin
              w_input_idx_nxt = '0;
              w_eos_nxt       = 1'b1;
              w_state_nxt     = ST_INPUT;
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end

        ST_INPUT: begin
          if (w_press) begin
            w_valid_nxt   = 1'b1;
            w_correct_nxt = w_hit;
            if (!w_hit) begin
              w_state_nxt = ST_FAIL;
            end else if (w_input_next == r_len) begin
              w_round_done_nxt = 1'b1;
              w_state_nxt      = ST_IDLE;
            end else begin
              w_input_idx_nxt = w_input_next;
            end
          end
        end

        default: ;  // IDLE and FAIL wait for start_round / new_game
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_state      <= ST_IDLE;
      r_lfsr       <= SEED;
      r_len        <= '0;
      r_play_idx   <= '0;
      r_input_idx  <= '0;
      r_cnt        <= '0;
      r_btn_prev   <= 4'b0000;
      r_random_seq <= 2'd0;
      r_eos        <= 1'b0;
      r_valid      <= 1'b0;
      r_correct    <= 1'b0;
      r_round_done <= 1'b0;
      r_max        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_lfsr       <= {r_lfsr[6:0], w_lfsr_fb};
      r_len        <= w_len_nxt;
      r_play_idx   <= w_play_idx_nxt;
      r_input_idx  <= w_input_idx_nxt;
      r_cnt        <= w_cnt_nxt;
      r_btn_prev   <= bus.btn;
      r_random_seq <= w_random_seq_nxt;
      r_eos        <= w_eos_nxt;
      r_valid      <= w_valid_nxt;
      r_correct    <= w_correct_nxt;
      r_round_done <= w_round_done_nxt;
      r_max        <= (w_len_nxt == MAX_LEN_V);
    end
  end

  // NOTE: the colour store has no reset; entries at or beyond r_len are never read, so clearing them buys nothing.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_addr] <= r_lfsr[1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.random_seq      = r_random_seq;
  assign bus.seq_active      = (r_state == ST_PLAY_ON);
  assign bus.end_of_sequence = r_eos;
  assign bus.input_valid     = r_valid;
  assign bus.correct_input   = r_correct;
  assign bus.round_complete  = r_round_done;
  assign bus.seq_length      = r_len;
  assign bus.max_reached     = r_max;

endmodule

// File: tb/tb_simon_sequencer.sv
// -----------------------------------------------------------------------------
// tb_simon_sequencer
//   Directed bench for simon_sequencer. A reference LFSR and a copy of the
//   expected colour list are kept on the bench side; playback timing and press
//   judging are checked cycle by cycle against them.
// -----------------------------------------------------------------------------
module tb_simon_sequencer;

  localparam int MAX_LEN = 16;
  localparam int ON_CYC  = 4;
  localparam int OFF_CYC = 2;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  simon_seq_if #(.MAX_LEN(MAX_LEN)) bus_if ();

  simon_sequencer #(
    .MAX_LEN        (MAX_LEN),
    .STEP_ON_CYCLES (ON_CYC),
    .STEP_OFF_CYCLES(OFF_CYC),
    .LFSR_SEED      (8'hA5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference LFSR: x^8 + x^6 + x^5 + x^4 + 1, reset to the seed.
  logic [7:0] m_lfsr;
  always @(posedge clk) begin
    if (rst) m_lfsr <= 8'hA5;
    else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  logic [1:0] exp_mem [MAX_LEN];
  int         exp_len = 0;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One cycle of reset, then every output must read zero.
  task automatic apply_reset(input string tag);
    rst = 1'b1;
    step();
    n_tests++; if (bus_if.random_seq !== 2'd0) begin n_fail++; $display("FAIL %s random_seq: got %0d want 0", tag, bus_if.random_seq); end
    n_tests++; if (bus_if.seq_active !== 1'b0) begin n_fail++; $display("FAIL %s seq_active: got %b want 0", tag, bus_if.seq_active); end
    n_tests++; if (bus_if.end_of_sequence !== 1'b0) begin n_fail++; $display("FAIL %s end_of_sequence: got %b want 0", tag, bus_if.end_of_sequence); end
    n_tests++; if (bus_if.input_valid !== 1'b0) begin n_fail++; $display("FAIL %s input_valid: got %b want 0", tag, bus_if.input_valid); end
    n_tests++; if (bus_if.correct_input !== 1'b0) begin n_fail++; $display("FAIL %s correct_input: got %b want 0", tag, bus_if.correct_input); end
    n_tests++; if (bus_if.round_complete !== 1'b0) begin n_fail++; $display("FAIL %s round_complete: got %b want 0", tag, bus_if.round_complete); end
    n_tests++; if (bus_if.seq_length !== '0) begin n_fail++; $display("FAIL %s seq_length: got %0d want 0", tag, bus_if.seq_length); end
    n_tests++; if (bus_if.max_reached !== 1'b0) begin n_fail++; $display("FAIL %s max_reached: got %b want 0", tag, bus_if.max_reached); end
    rst = 1'b0;
    exp_len = 0;
  endtask

  // Issue start_round (optionally with new_game) and check the full playback.
  task automatic start_and_play(input bit ng, input bit from_fail, input string tag);
    logic [1:0] col;
    col = m_lfsr[1:0];
    if (ng) exp_len = 0;
    if ((ng || !from_fail) && exp_len < MAX_LEN) begin
      exp_mem[exp_len] = col;
      exp_len++;
    end
    bus_if.new_game    = ng;
    bus_if.start_round = 1'b1;
    step();
    bus_if.new_game    = 1'b0;
    bus_if.start_round = 1'b0;
    n_tests++; if (bus_if.seq_length !== LEN_W'(exp_len)) begin n_fail++; $display("FAIL %s seq_length: got %0d want %0d", tag, bus_if.seq_length, exp_len); end
    n_tests++; if (bus_if.max_reached !== (exp_len == MAX_LEN)) begin n_fail++; $display("FAIL %s max_reached: got %b want %b", tag, bus_if.max_reached, exp_len == MAX_LEN); end
    n_tests++; if (bus_if.correct_input !== 1'b0) begin n_fail++; $display("FAIL %s correct_input cleared: got %b want 0", tag, bus_if.correct_input); end
    for (int i = 0; i < exp_len; i++) begin
      for (int c = 0; c < ON_CYC; c++) begin
        n_tests++;
        if (bus_if.seq_active !== 1'b1 || bus_if.random_seq !== exp_mem[i] || bus_if.end_of_sequence !== 1'b0) begin
          n_fail++;
          $display("FAIL %s on[%0d].%0d: active=%b col=%0d eos=%b want active=1 col=%0d eos=0",
                   tag, i, c, bus_if.seq_active, bus_if.random_seq, bus_if.end_of_sequence, exp_mem[i]);
        end
        step();
      end
      for (int c = 0; c < OFF_CYC; c++) begin
        n_tests++;
        if (bus_if.seq_active !== 1'b0 || bus_if.random_seq !== exp_mem[i] || bus_if.end_of_sequence !== 1'b0) begin
          n_fail++;
          $display("FAIL %s off[%0d].%0d: active=%b col=%0d eos=%b want active=0 col=%0d eos=0",
                   tag, i, c, bus_if.seq_active, bus_if.random_seq, bus_if.end_of_sequence, exp_mem[i]);
        end
        step();
      end
    end
    n_tests++; if (bus_if.end_of_sequence !== 1'b1) begin n_fail++; $display("FAIL %s eos pulse: got %b want 1", tag, bus_if.end_of_sequence); end
    step();
    n_tests++; if (bus_if.end_of_sequence !== 1'b0) begin n_fail++; $display("FAIL %s eos width: got %b want 0", tag, bus_if.end_of_sequence); end
  endtask

  // Press for one cycle, check the judged result, then release.
  task automatic press(input logic [3:0] val, input bit exp_valid, input bit exp_c,
                       input bit exp_rc, input string tag);
    bus_if.btn = val;
    step();
    n_tests++; if (bus_if.input_valid !== exp_valid) begin n_fail++; $display("FAIL %s input_valid: got %b want %b", tag, bus_if.input_valid, exp_valid); end
    n_tests++; if (bus_if.correct_input !== exp_c) begin n_fail++; $display("FAIL %s correct_input: got %b want %b", tag, bus_if.correct_input, exp_c); end
    n_tests++; if (bus_if.round_complete !== exp_rc) begin n_fail++; $display("FAIL %s round_complete: got %b want %b", tag, bus_if.round_complete, exp_rc); end
    bus_if.btn = 4'b0000;
    step();
    n_tests++; if (bus_if.input_valid !== 1'b0) begin n_fail++; $display("FAIL %s release input_valid: got %b want 0", tag, bus_if.input_valid); end
  endtask

  task automatic complete_round(input string tag);
    logic [3:0] v;
    for (int i = 0; i < exp_len; i++) begin
      v = 4'b0001 << exp_mem[i];
      press(v, 1'b1, 1'b1, (i == exp_len - 1), tag);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    apply_reset("reset");
  endtask

  task automatic test_first_round();
    logic [3:0] v;
    start_and_play(1'b1, 1'b0, "first_play");
    v = 4'b0001 << exp_mem[0];
    bus_if.btn = v;
    step();
    n_tests++; if (bus_if.input_valid !== 1'b1) begin n_fail++; $display("FAIL first_press input_valid: got %b want 1", bus_if.input_valid); end
    n_tests++; if (bus_if.correct_input !== 1'b1) begin n_fail++; $display("FAIL first_press correct_input: got %b want 1", bus_if.correct_input); end
    n_tests++; if (bus_if.round_complete !== 1'b1) begin n_fail++; $display("FAIL first_press round_complete: got %b want 1", bus_if.round_complete); end
    for (int c = 0; c < 10; c++) begin
      step();
      n_tests++;
      if (bus_if.input_valid !== 1'b0 || bus_if.round_complete !== 1'b0) begin
        n_fail++;
        $display("FAIL hold[%0d]: valid=%b rc=%b want 0 0", c, bus_if.input_valid, bus_if.round_complete);
      end
    end
    n_tests++; if (bus_if.correct_input !== 1'b1) begin n_fail++; $display("FAIL hold correct_input: got %b want 1", bus_if.correct_input); end
    bus_if.btn = 4'b0000;
    step();
  endtask

  task automatic test_fail_path();
    logic [3:0] v;
    start_and_play(1'b0, 1'b0, "len2_play");
    complete_round("len2_in");
    start_and_play(1'b0, 1'b0, "len3_play");
    press(4'b0001 << exp_mem[0], 1'b1, 1'b1, 1'b0, "len3_p0");
    press(4'b0001 << exp_mem[1], 1'b1, 1'b1, 1'b0, "len3_p1");
    v = 4'b0001 << 2'(exp_mem[2] + 2'd1);
    press(v, 1'b1, 1'b0, 1'b0, "len3_wrong");
    press(4'b0001 << exp_mem[2], 1'b0, 1'b0, 1'b0, "fail_ignored");
    start_and_play(1'b0, 1'b1, "retry_play");
  endtask

  task automatic test_multi_hot();
    press(4'b0001 << exp_mem[0], 1'b1, 1'b1, 1'b0, "mh_p0");
    press(4'b0101, 1'b1, 1'b0, 1'b0, "mh_multi");
    press(4'b0001 << exp_mem[1], 1'b0, 1'b0, 1'b0, "mh_after");
  endtask

  task automatic test_saturation();
    start_and_play(1'b1, 1'b0, "sat_1");
    complete_round("sat_in");
    for (int r = 2; r <= MAX_LEN; r++) begin
      start_and_play(1'b0, 1'b0, "sat_play");
      complete_round("sat_in");
    end
    n_tests++; if (bus_if.seq_length !== LEN_W'(MAX_LEN)) begin n_fail++; $display("FAIL sat seq_length: got %0d want %0d", bus_if.seq_length, MAX_LEN); end
    n_tests++; if (bus_if.max_reached !== 1'b1) begin n_fail++; $display("FAIL sat max_reached: got %b want 1", bus_if.max_reached); end
    start_and_play(1'b0, 1'b0, "sat_17");
    complete_round("sat_17_in");
  endtask

  task automatic test_reset_midplay();
    start_and_play(1'b1, 1'b0, "mid_r1");
    complete_round("mid_r1_in");
    start_and_play(1'b0, 1'b0, "mid_r2");
    complete_round("mid_r2_in");
    bus_if.start_round = 1'b1;
    step();
    bus_if.start_round = 1'b0;
    step();
    n_tests++; if (bus_if.seq_active !== 1'b1) begin n_fail++; $display("FAIL mid_r3 seq_active: got %b want 1", bus_if.seq_active); end
    apply_reset("mid_reset");
    start_and_play(1'b0, 1'b0, "post_reset");
    complete_round("post_reset_in");
  endtask

  initial begin
    bus_if.new_game    = 1'b0;
    bus_if.start_round = 1'b0;
    bus_if.btn         = 4'b0000;
    step();
    test_reset();
    test_first_round();
    test_fail_path();
    test_multi_hot();
    test_saturation();
    test_reset_midplay();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
